// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES-to-UART block transmitter.
// Holds the transmit FSM encoding and the default block geometry.
package aes_uart_pkg;

    localparam int unsigned DEF_NUM_BYTES  = 16;
    localparam int unsigned DEF_GAP_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_DONE,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/aes_block_tx.sv
// Serialises one AES block into a byte stream for a UART transmitter.
// A one-entry hold register lets the next block queue while one is sent.
module aes_block_tx
    import aes_uart_pkg::*;
#(
    parameter int unsigned NUM_BYTES  = DEF_NUM_BYTES,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   blk_valid,
    input  logic [8*NUM_BYTES-1:0] blk_data,
    output logic                   blk_ready,
    output logic                   tx_start,
    output logic [7:0]             d_out,
    input  logic                   tx_done_flag,
    output logic                   busy,
    output logic                   blk_done
);

    localparam int unsigned W  = 8 * NUM_BYTES;
    localparam int unsigned CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES - 1);
    localparam logic [GW-1:0] LAST_GAP  =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_t     state;
    logic [W-1:0]  hold_data;
    logic [W-1:0]  shift_reg;
    logic [W-1:0]  shift_nxt;
    logic          hold_full;
    logic          hold_full_nxt;
    logic          accept;
    logic [CW-1:0] count;
    logic [GW-1:0] gap_cnt;

    assign accept    = blk_valid & blk_ready;
    assign shift_nxt = shift_reg << 8;

    // Hold occupancy: LOAD drains the entry, an accepted block refills it
    always_comb begin
        hold_full_nxt = hold_full;
        if (state == ST_LOAD) hold_full_nxt = 1'b0;
        if (accept) hold_full_nxt = 1'b1;
    end

    // Hold register and its registered ready flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            blk_ready <= 1'b0;
        end else begin
            hold_full <= hold_full_nxt;
            blk_ready <= ~hold_full_nxt;
            if (accept) hold_data <= blk_data;
        end
    end

    // Transmit FSM; outputs are set on the edge entering each state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            count     <= '0;
            gap_cnt   <= '0;
            tx_start  <= 1'b0;
            d_out     <= '0;
            busy      <= 1'b0;
            blk_done  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            blk_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (hold_full) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shift_reg <= hold_data;
                    count     <= '0;
                    state     <= ST_START;
                    tx_start  <= 1'b1;
                    d_out     <= hold_data[W-1 -: 8];
                end
                ST_START: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done_flag) begin
                        shift_reg <= shift_nxt;
                        if (count == LAST_BYTE) begin
                            blk_done <= 1'b1;
                            if (hold_full) begin
                                state <= ST_LOAD;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            count <= count + 1'b1;
                            if (GAP_CYCLES == 0) begin
                                state    <= ST_START;
                                tx_start <= 1'b1;
                                d_out    <= shift_nxt[W-1 -: 8];
                            end else begin
                                state   <= ST_GAP;
                                gap_cnt <= '0;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state    <= ST_START;
                        tx_start <= 1'b1;
                        d_out    <= shift_reg[W-1 -: 8];
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_tx.sv
// Directed bench for aes_block_tx with a behavioural UART done responder.
// A second instance exercises the zero-gap configuration.
module tb_aes_block_tx;

    localparam logic [127:0] BLK1  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_A = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] BLK_B = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    localparam int DONE_DLY = 5;

    logic         clk;
    logic         reset;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         tx_start;
    logic [7:0]   d_out;
    logic         tx_done_flag;
    logic         busy;
    logic         blk_done;

    logic         g_valid;
    logic [127:0] g_data;
    logic         g_ready;
    logic         g_tx_start;
    logic [7:0]   g_d_out;
    logic         g_flag;
    logic         g_busy;
    logic         g_blk_done;

    logic auto_en;
    logic auto_flag;
    logic man_flag;
    int   wait_n;

    logic [7:0] byte_q[$];
    int         start_q[$];
    int         done_q[$];
    int         cyc;
    int         done_cnt;

    int n_chk;
    int n_pass;

    assign tx_done_flag = auto_flag | man_flag;

    aes_block_tx u_dut (
        .clk          (clk),
        .reset        (reset),
        .blk_valid    (blk_valid),
        .blk_data     (blk_data),
        .blk_ready    (blk_ready),
        .tx_start     (tx_start),
        .d_out        (d_out),
        .tx_done_flag (tx_done_flag),
        .busy         (busy),
        .blk_done     (blk_done)
    );

    aes_block_tx #(.NUM_BYTES(16), .GAP_CYCLES(0)) u_gap0 (
        .clk          (clk),
        .reset        (reset),
        .blk_valid    (g_valid),
        .blk_data     (g_data),
        .blk_ready    (g_ready),
        .tx_start     (g_tx_start),
        .d_out        (g_d_out),
        .tx_done_flag (g_flag),
        .busy         (g_busy),
        .blk_done     (g_blk_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte start and block completion seen by the UART side
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_start === 1'b1) begin
            byte_q.push_back(d_out);
            start_q.push_back(cyc);
        end
        if (blk_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_q.push_back(cyc);
        end
    end

    // UART model: byte-complete pulse DONE_DLY cycles after each start
    always @(negedge clk) begin
        auto_flag = 1'b0;
        if (reset !== 1'b1) begin
            wait_n = 0;
        end else begin
            if (wait_n > 0) begin
                wait_n = wait_n - 1;
                if (wait_n == 0) auto_flag = 1'b1;
            end
            if (auto_en && tx_start === 1'b1) wait_n = DONE_DLY;
        end
    end

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [127:0] d, input string tag);
        int k = 0;
        while (blk_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, longint'(k < 300), 1);
        blk_data  = d;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (tx_start !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, longint'(tx_start), 1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (done_cnt < target && k < 1500) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check(tag, done_cnt, target);
    endtask

    initial begin
        int base;
        int dbase;
        int bad;
        int k;

        cyc       = 0;
        done_cnt  = 0;
        n_chk     = 0;
        n_pass    = 0;
        wait_n    = 0;
        auto_flag = 1'b0;
        reset     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        man_flag  = 1'b0;
        auto_en   = 1'b1;
        g_valid   = 1'b0;
        g_data    = '0;
        g_flag    = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_d_out", d_out, 0);
        check("rst_busy", busy, 0);
        check("rst_blk_done", blk_done, 0);
        check("rst_blk_ready", blk_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", blk_ready, 1);
        check("g0_ready_after_rst", g_ready, 1);

        // single block, accept-to-start latency and byte order
        base  = byte_q.size();
        dbase = done_cnt;
        blk_data  = BLK1;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        check("ready_low_after_accept", blk_ready, 0);
        check("lat_no_start_c0", tx_start, 0);
        @(negedge clk);
        check("lat_no_start_c1", tx_start, 0);
        check("busy_in_load", busy, 1);
        @(negedge clk);
        check("lat_start_c2", tx_start, 1);
        check("lat_first_byte", d_out, 8'h00);
        wait_done(dbase + 1, "b1_done");
        check("b1_count", byte_q.size() - base, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("b1_byte%0d", i), byte_q[base+i], (i * 17) & 8'hFF);
        bad = 0;
        for (int i = 1; i < 16; i++)
            if (start_q[base+i] - start_q[base+i-1] != DONE_DLY + 3) bad++;
        check("b1_spacing_bad", bad, 0);
        check("b1_idle_busy", busy, 0);
        check("b1_idle_ready", blk_ready, 1);

        // back-to-back blocks A then B
        base  = byte_q.size();
        dbase = done_cnt;
        send(BLK_A, "b2b_send_a");
        send(BLK_B, "b2b_send_b");
        check("b2b_ready_low_after_b", blk_ready, 0);
        wait_done(dbase + 2, "b2b_done");
        check("b2b_count", byte_q.size() - base, 32);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (byte_q[base+i] !== 8'(i)) bad++;
            if (byte_q[base+16+i] !== 8'(8'hF0 + i)) bad++;
        end
        check("b2b_byte_order_bad", bad, 0);
        check("b2b_b_start_after_done", start_q[base+16] - done_q[dbase], 1);

        // spurious done flags in IDLE and GAP
        auto_en  = 1'b0;
        man_flag = 1'b1;
        @(negedge clk);
        man_flag = 1'b0;
        @(negedge clk);
        check("idle_spur_no_start", tx_start, 0);
        check("idle_spur_busy", busy, 0);
        base  = byte_q.size();
        dbase = done_cnt;
        send(BLK1, "spur_send");
        wait_start("spur_first_start");
        check("spur_b0", d_out, 8'h00);
        repeat (3) @(negedge clk);
        man_flag = 1'b1;
        repeat (2) @(negedge clk);
        man_flag = 1'b0;
        auto_en  = 1'b1;
        @(negedge clk);
        check("spur_gap_start", tx_start, 1);
        check("spur_gap_byte", d_out, 8'h11);
        wait_done(dbase + 1, "spur_done");
        check("spur_count", byte_q.size() - base, 16);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (byte_q[base+i] !== 8'((i * 17) & 8'hFF)) bad++;
        check("spur_byte_order_bad", bad, 0);

        // reset after the seventh byte starts
        base = byte_q.size();
        send(BLK1, "rstmid_send");
        k = 0;
        while (byte_q.size() < base + 7 && k < 300) begin
            @(negedge clk);
            k++;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_tx_start", tx_start, 0);
        check("rstmid_busy", busy, 0);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("rstmid_no_more_starts", byte_q.size() - base, 7);
        check("rstmid_idle", busy, 0);
        base  = byte_q.size();
        dbase = done_cnt;
        send(BLK_B, "rstmid_send2");
        wait_done(dbase + 1, "rstmid_done2");
        check("rstmid_count2", byte_q.size() - base, 16);
        check("rstmid_first_byte", byte_q[base], 8'hF0);
        check("rstmid_last_byte", byte_q[base+15], 8'hFF);

        // long-delayed done leaves outputs stable
        auto_en = 1'b0;
        base  = byte_q.size();
        dbase = done_cnt;
        send(BLK_B, "slow_send");
        wait_start("slow_first_start");
        check("slow_b0", d_out, 8'hF0);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (d_out !== 8'hF0 || busy !== 1'b1 || tx_start !== 1'b0) bad++;
        end
        check("slow_stable_bad", bad, 0);
        check("slow_no_repeat", byte_q.size() - base, 1);
        man_flag = 1'b1;
        auto_en  = 1'b1;
        @(negedge clk);
        man_flag = 1'b0;
        wait_done(dbase + 1, "slow_done");
        check("slow_count", byte_q.size() - base, 16);
        check("slow_byte1", byte_q[base+1], 8'hF1);

        // zero-gap instance: next start one cycle after done
        g_data  = BLK1;
        g_valid = 1'b1;
        @(negedge clk);
        g_valid = 1'b0;
        k = 0;
        while (g_tx_start !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("g0_first_start", g_tx_start, 1);
        check("g0_b0", g_d_out, 8'h00);
        repeat (2) @(negedge clk);
        check("g0_no_start_before_done", g_tx_start, 0);
        g_flag = 1'b1;
        @(negedge clk);
        g_flag = 1'b0;
        check("g0_start_1cyc_b1", g_tx_start, 1);
        check("g0_b1", g_d_out, 8'h11);
        repeat (3) @(negedge clk);
        g_flag = 1'b1;
        @(negedge clk);
        g_flag = 1'b0;
        check("g0_start_1cyc_b2", g_tx_start, 1);
        check("g0_b2", g_d_out, 8'h22);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
